// File: rtl/header_padder.sv
// header_padder: collects the 76 fixed bytes of a Bitcoin block header and
// then sweeps a nonce range. For each nonce it presents one SHA-256-padded
// 1024-bit message (two 512-bit blocks) and holds it until it is acknowledged.
module header_padder #(
  parameter bit          NONCE_BSWAP = 1'b1,
  parameter logic [63:0] LEN_BITS    = 64'd640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   hdr_word,
  input  logic          hdr_valid,
  output logic          hdr_ready,
  input  logic [31:0]   nonce_start,
  input  logic [31:0]   nonce_end,
  input  logic          go,
  output logic [1023:0] message,
  output logic          msg_valid,
  input  logic          msg_ack,
  output logic [31:0]   cur_nonce,
  output logic          done
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    WAIT_GO = 3'd1,
    BUILD   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned HDR_WORDS = 19;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [31:0]     hdr_q [HDR_WORDS];
  logic [31:0]     hdr_d [HDR_WORDS];
  logic [31:0]     cur_nonce_q, cur_nonce_d;
  logic [31:0]     end_q, end_d;
  logic [1023:0]   message_q, message_d;
  logic            msg_valid_q, msg_valid_d;
  logic            done_q, done_d;
  logic            hdr_ready_q, hdr_ready_d;

  logic [31:0]     nonce_ins;
  logic [1023:0]   msg_build;

  // Nonce as it appears in the header field (optionally byte-reversed).
  always_comb begin
    nonce_ins = cur_nonce_q;
    if (NONCE_BSWAP) begin
      nonce_ins = {cur_nonce_q[7:0], cur_nonce_q[15:8],
                   cur_nonce_q[23:16], cur_nonce_q[31:24]};
    end
  end

  // Padded message image: header, nonce, 0x80 pad byte, zeros, 64-bit length.
  always_comb begin
    msg_build = '0;
    for (int unsigned k = 0; k < HDR_WORDS; k++) begin
      msg_build[1023 - 32*k -: 32] = hdr_q[k];
    end
    msg_build[1023 - 32*19 -: 32] = nonce_ins;
    msg_build[1023 - 32*20 -: 32] = 32'h8000_0000;
    msg_build[1023 - 32*30 -: 32] = LEN_BITS[63:32];
    msg_build[1023 - 32*31 -: 32] = LEN_BITS[31:0];
  end

  // Next-state and datapath; status outputs are derived from the next state
  // so they are registered yet line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    cur_nonce_d = cur_nonce_q;
    end_d       = end_q;
    message_d   = message_q;

    unique case (state_q)
      LOAD: begin
        if (hdr_valid) begin
          hdr_d[idx_q] = hdr_word;
          if (idx_q == 5'd18) begin
            idx_d   = '0;
            state_d = WAIT_GO;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      WAIT_GO: begin
        if (go) begin
          cur_nonce_d = nonce_start;
          end_d       = nonce_end;
          state_d     = BUILD;
        end
      end
      BUILD: begin
        message_d = msg_build;
        state_d   = PRESENT;
      end
      PRESENT: begin
        if (msg_ack) begin
          if (cur_nonce_q == end_q) begin
            state_d = DONE;
          end else begin
            cur_nonce_d = cur_nonce_q + 32'd1;
            state_d     = BUILD;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = LOAD;
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD;
      end
    endcase

    hdr_ready_d = (state_d == LOAD);
    msg_valid_d = (state_d == PRESENT);
    done_d      = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      hdr_q       <= '{default: '0};
      cur_nonce_q <= '0;
      end_q       <= '0;
      message_q   <= '0;
      msg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      hdr_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      cur_nonce_q <= cur_nonce_d;
      end_q       <= end_d;
      message_q   <= message_d;
      msg_valid_q <= msg_valid_d;
      done_q      <= done_d;
      hdr_ready_q <= hdr_ready_d;
    end
  end

  assign hdr_ready = hdr_ready_q;
  assign message   = message_q;
  assign msg_valid = msg_valid_q;
  assign cur_nonce = cur_nonce_q;
  assign done      = done_q;

endmodule

// File: tb/tb_header_padder.sv
// Directed bench for header_padder: two instances (nonce byte-swap on/off)
// share stimulus; expected nonces are queued at go and checked per message.
module tb_header_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   hdr_word;
  logic          hdr_valid;
  logic [31:0]   nonce_start, nonce_end;
  logic          go;
  logic          msg_ack;

  logic          hdr_ready, msg_valid, done;
  logic [1023:0] message;
  logic [31:0]   cur_nonce;
  logic          hdr_ready0, msg_valid0, done0;
  logic [1023:0] message0;
  logic [31:0]   cur_nonce0;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [31:0]   exp_hdr [19];
  logic [31:0]   sb_q [$];

  always #5 clk = ~clk;

  header_padder u_dut (
    .clk(clk), .rst(rst), .hdr_word(hdr_word), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .go(go), .message(message), .msg_valid(msg_valid), .msg_ack(msg_ack),
    .cur_nonce(cur_nonce), .done(done)
  );

  header_padder #(.NONCE_BSWAP(1'b0), .LEN_BITS(64'd640)) u_dut0 (
    .clk(clk), .rst(rst), .hdr_word(hdr_word), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready0), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .go(go), .message(message0), .msg_valid(msg_valid0), .msg_ack(msg_ack),
    .cur_nonce(cur_nonce0), .done(done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected word k of the padded message for a given nonce.
  function automatic logic [31:0] exp_word(input int k, input logic [31:0] n, input bit bswap);
    if (k < 19)       return exp_hdr[k];
    else if (k == 19) return bswap ? {n[7:0], n[15:8], n[23:16], n[31:24]} : n;
    else if (k == 20) return 32'h8000_0000;
    else if (k == 31) return 32'h0000_0280;
    else              return 32'h0000_0000;
  endfunction

  task automatic chk_msg(input string tag, input logic [31:0] n);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("%s swap w%0d", tag, k), message[1023 - 32*k -: 32], exp_word(k, n, 1'b1));
      chk($sformatf("%s noswap w%0d", tag, k), message0[1023 - 32*k -: 32], exp_word(k, n, 1'b0));
    end
  endtask

  // Load 19 header words; with gaps, idle cycles carry go and junk data.
  task automatic load_header(input logic [31:0] base, input bit gaps);
    chk("load hdr_ready", {31'd0, hdr_ready}, 32'd1);
    for (int i = 0; i < 19; i++) begin
      exp_hdr[i] = base + 32'(i);
      hdr_valid  = 1'b1;
      hdr_word   = base + 32'(i);
      tick();
      hdr_valid  = 1'b0;
      if (gaps && i < 18) begin
        hdr_word = 32'hDEAD_0000 + 32'(i);
        go       = 1'b1;
        tick();
        go       = 1'b0;
        chk("gap msg_valid", {31'd0, msg_valid}, 32'd0);
      end
    end
    chk("loaded hdr_ready", {31'd0, hdr_ready}, 32'd0);
  endtask

  task automatic start(input logic [31:0] ns, input logic [31:0] ne);
    logic [31:0] n;
    nonce_start = ns;
    nonce_end   = ne;
    go = 1'b1;
    tick();
    go = 1'b0;
    nonce_start = 32'hAAAA_AAAA;
    nonce_end   = 32'h5555_5555;
    n = ns;
    sb_q.push_back(n);
    while (n != ne) begin
      n = n + 32'd1;
      sb_q.push_back(n);
    end
  endtask

  // Wait for a message, compare it with the queue head, hold it for delay
  // cycles, then optionally acknowledge and check the follow-up state.
  task automatic take_msg(input int delay, input bit last, input bit do_ack);
    int cnt;
    logic [31:0] n;
    cnt = 0;
    while (!msg_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("msg latency", 32'(cnt), 32'd1);
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed unexpected message expected none");
      return;
    end
    n = sb_q.pop_front();
    chk("cur_nonce", cur_nonce, n);
    chk("cur_nonce0", cur_nonce0, n);
    chk_msg("msg", n);
    for (int d = 0; d < delay; d++) begin
      tick();
      chk("hold msg_valid", {31'd0, msg_valid}, 32'd1);
      chk("hold cur_nonce", cur_nonce, n);
      chk("hold w19", message[1023 - 32*19 -: 32], exp_word(19, n, 1'b1));
      chk("hold w0", message[1023 -: 32], exp_hdr[0]);
    end
    if (!do_ack) return;
    msg_ack = 1'b1;
    tick();
    msg_ack = 1'b0;
    chk("post-ack msg_valid", {31'd0, msg_valid}, 32'd0);
    chk("post-ack done", {31'd0, done}, last ? 32'd1 : 32'd0);
    if (last) begin
      tick();
      chk("after done", {31'd0, done}, 32'd0);
      chk("after done hdr_ready", {31'd0, hdr_ready}, 32'd1);
      chk("after done msg_valid", {31'd0, msg_valid}, 32'd0);
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    end
  endtask

  task automatic chk_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk(tag, {31'd0, msg_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; hdr_word = '0; hdr_valid = 1'b0; go = 1'b0; msg_ack = 1'b0;
    nonce_start = '0; nonce_end = '0;
    tick();
    tick();
    chk("rst hdr_ready", {31'd0, hdr_ready}, 32'd1);
    chk("rst msg_valid", {31'd0, msg_valid}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst cur_nonce", cur_nonce, 32'd0);
    chk("rst msg w0", message[1023 -: 32], 32'd0);
    chk("rst msg w31", message[31:0], 32'd0);
    rst = 1'b1;
    tick();

    // Single nonce.
    load_header(32'h0000_0001, 1'b0);
    start(32'h0000_0005, 32'h0000_0005);
    take_msg(0, 1'b1, 1'b1);

    // Sweep 0x10..0x12 with ack delays 0, 3, 7.
    load_header(32'hA000_0100, 1'b0);
    start(32'h0000_0010, 32'h0000_0012);
    take_msg(0, 1'b0, 1'b1);
    take_msg(3, 1'b0, 1'b1);
    take_msg(7, 1'b1, 1'b1);
    chk_idle("post-sweep msg_valid", 4);

    // Wrap through 0xFFFFFFFF.
    load_header(32'h1234_0000, 1'b0);
    start(32'hFFFF_FFFE, 32'h0000_0001);
    take_msg(0, 1'b0, 1'b1);
    take_msg(0, 1'b0, 1'b1);
    take_msg(0, 1'b0, 1'b1);
    take_msg(0, 1'b1, 1'b1);

    // Gapped load, go during LOAD, ack and junk data in WAIT_GO.
    load_header(32'h0BAD_F000, 1'b1);
    msg_ack = 1'b1; hdr_valid = 1'b1; hdr_word = 32'hDEAD_BEEF;
    tick();
    msg_ack = 1'b0; hdr_valid = 1'b0;
    chk("wait_go msg_valid", {31'd0, msg_valid}, 32'd0);
    chk_idle("wait_go idle", 3);
    start(32'h1234_5678, 32'h1234_5678);
    take_msg(2, 1'b1, 1'b1);

    // Reset while presenting nonce 0x11 of 0x10..0x20.
    load_header(32'h0000_0100, 1'b0);
    start(32'h0000_0010, 32'h0000_0020);
    take_msg(0, 1'b0, 1'b1);
    take_msg(1, 1'b0, 1'b0);
    sb_q.delete();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst msg_valid", {31'd0, msg_valid}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst hdr_ready", {31'd0, hdr_ready}, 32'd1);
    chk("midrst cur_nonce", cur_nonce, 32'd0);
    chk("midrst msg w19", message[1023 - 32*19 -: 32], 32'd0);
    msg_ack = 1'b1; go = 1'b1;
    tick();
    msg_ack = 1'b0; go = 1'b0;
    chk("midrst go ignored", {31'd0, msg_valid}, 32'd0);
    chk_idle("midrst idle", 6);
    chk("midrst still loading", {31'd0, hdr_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/header_padder.md
Name: header_padder

Overview:
- Upstream feeder for the SHA-256 schedule/compression stage.
- Collects the 76 fixed bytes of an 80-byte Bitcoin block header as a 32-bit word stream, then sweeps a nonce range.
- For each nonce it emits one SHA-256-padded 1024-bit message (two 512-bit blocks), holding it until the consumer acknowledges.

Parameters:
- NONCE_BSWAP, 1: 1 = byte-reverse the nonce before insertion (little-endian header field); 0 = insert as-is.
- LEN_BITS, 640: message length written into the 64-bit length field.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- hdr_word  input  32  header word, big-endian word order
- hdr_valid  input  1  hdr_word valid
- hdr_ready  output  1  block accepts hdr_word this cycle
- nonce_start  input  32  first nonce of sweep, sampled on go
- nonce_end  input  32  last nonce of sweep, sampled on go
- go  input  1  start sweep
- message  output  1024  padded message; word k = message[1023-32k -: 32]
- msg_valid  output  1  message valid
- msg_ack  input  1  consumer has taken message
- cur_nonce  output  32  nonce (un-swapped) carried in message
- done  output  1  one-cycle pulse after last message acked

Behaviour:
- Reset (rst==0 at posedge) overrides everything:
  - state=LOAD, word index=0, hdr_ready=1.
  - msg_valid=0, done=0, message=0, cur_nonce=0.
  - Stored header words cleared.
  - Legal mid-sweep; no further messages are issued.
- States: LOAD, WAIT_GO, BUILD, PRESENT, DONE.
- LOAD:
  - hdr_ready=1.
  - Each cycle with hdr_valid=1, hdr_word is stored at the current index (0..18) and the index increments.
  - Gaps in hdr_valid are allowed.
  - When word 18 is accepted, go to WAIT_GO and drop hdr_ready the next cycle.
  - go is ignored in LOAD.
- WAIT_GO:
  - hdr_ready=0.
  - When go=1, latch nonce_start into cur_nonce and nonce_end into an internal end register, then go to BUILD.
- BUILD (1 cycle): assemble message:
  - words 0..18 = stored header
  - word 19 = cur_nonce, byte-reversed if NONCE_BSWAP
  - word 20 = 0x80000000
  - words 21..29 = 0
  - word 30 = LEN_BITS[63:32]
  - word 31 = LEN_BITS[31:0]
  - Then go to PRESENT.
- PRESENT:
  - msg_valid=1; message and cur_nonce stable.
  - On msg_ack=1:
    - If cur_nonce==end register, go to DONE.
    - Otherwise cur_nonce <= cur_nonce+1 (mod 2^32) and go to BUILD.
  - msg_valid deasserts the cycle after ack.
- DONE: done=1 for exactly one cycle; index reset to 0; go to LOAD (new header required).
- Latency:
  - go high at cycle t in WAIT_GO → msg_valid high at t+2.
  - msg_ack at t → msg_valid low at t+1, high at t+2 with the next nonce.
- Wrap-around: nonce increments modulo 2^32; the sweep terminates only on equality with the end register. nonce_start > nonce_end therefore wraps through 0xFFFFFFFF→0x00000000.
- msg_ack outside PRESENT is ignored. hdr_valid outside LOAD is ignored (not stored).
- Inputs nonce_start/nonce_end may change after go without effect.
- Every message is presented at least once. Equal start/end → exactly one message.

Test Plan:
- Single nonce:
  - Stimulus: reset; feed words 0x00000001..0x00000013 with hdr_valid continuous; go with nonce_start=nonce_end=0x00000005, NONCE_BSWAP=1.
  - Required response: one message with words 0..18 = 0x01..0x13, word19=0x05000000, word20=0x80000000, words21..30=0, word31=0x00000280. After ack, done pulses 1 cycle, then hdr_ready=1.
- Sweep with backpressure:
  - Stimulus: nonce_start=0x10, nonce_end=0x12; ack delayed 0, 3 and 7 cycles.
  - Required response: exactly three messages with cur_nonce 0x10, 0x11, 0x12. message stable while msg_valid and un-acked. done after the third ack only.
- Wrap:
  - Stimulus: nonce_start=0xFFFFFFFE, nonce_end=0x00000001; ack every message immediately.
  - Required response: cur_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, then done. Four messages total.
- Input gaps and ignores:
  - Stimulus: hdr_valid toggled 1010…; go pulsed during LOAD; msg_ack pulsed in WAIT_GO.
  - Required response: all 19 words stored in order. No sweep starts until go is pulsed in WAIT_GO. No spurious msg_valid.
- Reset mid-sweep:
  - Stimulus: rst=0 for one cycle while PRESENT with nonce 0x11 of a 0x10..0x20 sweep.
  - Required response: next cycle msg_valid=0, done=0, hdr_ready=1, cur_nonce=0. No further messages without a full new header load and go.
- NONCE_BSWAP=0:
  - Stimulus: nonce_start=nonce_end=0x12345678.
  - Required response: word19=0x12345678; other words as in the single-nonce case.
